matrix_mac_engine: RTL and testbench

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/mmac_if.sv | 28 ++
 rtl/matrix_mac_engine.sv | 141 ++++++++++++++
 tb/tb_matrix_mac_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmac_if.sv
// Operand/result handshake bundle for matrix_mac_engine.
// The engine uses the slave modport; the producer/consumer side uses master.
interface mmac_if #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int RW = 2 * W
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_select;
    logic [N*N*W-1:0]    dataa;
    logic [N*N*W-1:0]    datab;
    logic                out_valid;
    logic                out_ready;
    logic [N*N*RW-1:0]   result;
    logic                ovf;
    logic                busy;

    modport slave (
        input  in_valid, in_select, dataa, datab, out_ready,
        output in_ready, out_valid, result, ovf, busy
    );

    modport master (
        output in_valid, in_select, dataa, datab, out_ready,
        input  in_ready, out_valid, result, ovf, busy
    );
endinterface

// File: rtl/matrix_mac_engine.sv
// N x N unsigned matrix multiply / multiply-accumulate / element-wise / clear engine.
// One k-step of the outer-product accumulation per cycle, all N*N elements in parallel.
module matrix_mac_engine #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int RW = 2 * W
) (
    input  logic  clk,
    input  logic  reset,
    mmac_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_e;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MAC = 2'b01, OP_EWISE = 2'b10, OP_CLEAR = 2'b11} op_e;

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    // Sum width keeps one carry bit above whichever is wider: accumulator or full product.
    localparam int SW = ((RW > 2 * W) ? RW : 2 * W) + 1;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    op_e             op_q;
    logic [W-1:0]    a_q [N][N];
    logic [W-1:0]    b_q [N][N];
    logic [RW-1:0]   c_q [N][N];
    logic [RW-1:0]   c_d [N][N];
    logic            ovf_q, ovf_d;
    logic            accept;

    assign accept = (state_q == S_IDLE) && bus.in_valid;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_COMPUTE;
                    k_d     = '0;
                end
            end
            S_COMPUTE: begin
                if (op_q == OP_MUL || op_q == OP_MAC) begin
                    if (k_q == KW'(N - 1)) state_d = S_DONE;
                    else                   k_d     = k_q + 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic [2*W-1:0] prod;
        logic [SW-1:0]  sum;
        prod  = '0;
        sum   = '0;
        c_d   = c_q;
        ovf_d = ovf_q;
        if (accept) begin
            // MAC keeps the running accumulator; every other fresh op starts from zero.
            if (bus.in_select == OP_MUL || bus.in_select == OP_EWISE) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        c_d[r][c] = '0;
                ovf_d = 1'b0;
            end
        end else if (state_q == S_COMPUTE) begin
            case (op_q)
                OP_MUL, OP_MAC: begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            prod = (2*W)'(a_q[r][k_q]) * (2*W)'(b_q[k_q][c]);
                            sum  = SW'(c_q[r][c]) + SW'(prod);
                            c_d[r][c] = sum[RW-1:0];
                            if (|sum[SW-1:RW]) ovf_d = 1'b1;
                        end
                    end
                end
                OP_EWISE: begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            prod = (2*W)'(a_q[r][c]) * (2*W)'(b_q[r][c]);
                            c_d[r][c] = RW'(prod);
                        end
                    end
                end
                default: begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            c_d[r][c] = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            ovf_q   <= 1'b0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    c_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            c_q     <= c_d;
        end
    end

    // Operand capture is only meaningful after an accept, so these carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_e'(bus.in_select);
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= bus.dataa[(r*N+c)*W +: W];
                    b_q[r][c] <= bus.datab[(r*N+c)*W +: W];
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ovf       = ovf_q;

    always_comb begin
        bus.result = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bus.result[(r*N+c)*RW +: RW] = c_q[r][c];
    end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Randomized bench for matrix_mac_engine with a matrix-arithmetic reference model
// and a per-cycle compare process, plus literal checks for the directed scenarios.
module tb_matrix_mac_engine;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int RW = 32;
    localparam logic [1:0] MUL = 2'b00, MAC = 2'b01, EWISE = 2'b10, CLR = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mmac_if #(.N(N), .W(W), .RW(RW)) bus ();

    matrix_mac_engine #(.N(N), .W(W), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int unsigned   am [N][N];
    int unsigned   bm [N][N];
    logic [RW-1:0] exp_c [N][N];
    logic          exp_ovf = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint elem(input int r, input int c);
        return longint'(bus.result[(r*N+c)*RW +: RW]);
    endfunction

    // Reference: whole-matrix arithmetic in 64 bits; any element total reaching 2^RW wrapped.
    task automatic model_apply(input logic [1:0] sel);
        longint unsigned total;
        logic ovf_new;
        ovf_new = (sel == MAC) ? exp_ovf : 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (sel)
                    MUL, MAC: begin
                        total = (sel == MAC) ? longint'(exp_c[r][c]) : 64'd0;
                        for (int k = 0; k < N; k++)
                            total += longint'(am[r][k]) * longint'(bm[k][c]);
                        if ((total >> RW) != 0) ovf_new = 1'b1;
                        exp_c[r][c] = total[RW-1:0];
                    end
                    EWISE: begin
                        total = longint'(am[r][c]) * longint'(bm[r][c]);
                        exp_c[r][c] = total[RW-1:0];
                    end
                    default: exp_c[r][c] = '0;
                endcase
            end
        end
        exp_ovf = ovf_new;
    endtask

    task automatic model_zero();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_c[r][c] = '0;
        exp_ovf = 1'b0;
    endtask

    task automatic fill(input int unsigned av, input int unsigned bv);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                am[r][c] = av;
                bm[r][c] = bv;
            end
    endtask

    task automatic fill_random(input int kind);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0:       begin am[r][c] = $urandom_range(0, 65535); bm[r][c] = $urandom_range(0, 65535); end
                    1:       begin am[r][c] = $urandom_range(0, 15);    bm[r][c] = $urandom_range(0, 15);    end
                    default: begin am[r][c] = $urandom_range(65000, 65535); bm[r][c] = $urandom_range(65000, 65535); end
                endcase
            end
    endtask

    task automatic noise();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_select = 2'($urandom_range(0, 3));
        for (int i = 0; i < N*N; i++) begin
            bus.dataa[i*W +: W] = W'($urandom);
            bus.datab[i*W +: W] = W'($urandom);
        end
    endtask

    task automatic drive_operands(input logic [1:0] sel);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                bus.dataa[(r*N+c)*W +: W] = W'(am[r][c]);
                bus.datab[(r*N+c)*W +: W] = W'(bm[r][c]);
            end
        bus.in_select = sel;
        bus.in_valid  = 1'b1;
    endtask

    task automatic accept_op(input logic [1:0] sel);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", bus.in_ready, 1);
        drive_operands(sel);
        @(posedge clk);
        model_apply(sel);
        #1;
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic do_op(input logic [1:0] sel, input int hold);
        int lat;
        accept_op(sel);
        lat = 1;
        noise();
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid) begin
                lat++;
                noise();
            end
        end
        check("latency", lat, (sel == MUL || sel == MAC) ? N : 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            noise();
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("return_idle_ready", bus.in_ready, 1);
        check("return_idle_valid", bus.out_valid, 0);
    endtask

    // Per-cycle compare: whenever the result is architecturally visible it must match the model.
    always @(negedge clk) begin
        if (reset) begin
            check("busy_vs_ready", bus.busy, !bus.in_ready);
            if (bus.out_valid || bus.in_ready) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        check("result_vs_model", elem(r, c), longint'(exp_c[r][c]));
                check("ovf_vs_model", bus.ovf, exp_ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_select = 2'b00;
        bus.dataa     = '0;
        bus.datab     = '0;
        bus.out_ready = 1'b0;
        model_zero();
        #12;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_ovf", bus.ovf, 0);
        check("reset_result", elem(N-1, N-1), 0);
        @(negedge clk);
        reset = 1'b1;

        // Identity times counting matrix
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                am[r][c] = (r == c) ? 1 : 0;
                bm[r][c] = r*4 + c + 1;
            end
        do_op(MUL, 0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check("identity_mul", elem(r, c), r*4 + c + 1);
        check("identity_ovf", bus.ovf, 0);

        // Ones MUL then MAC, then EWISE discards the accumulation
        fill(1, 1);
        do_op(MUL, 0);
        check("ones_mul", elem(2, 1), 4);
        do_op(MAC, 0);
        check("ones_mac", elem(3, 3), 8);
        check("ones_mac0", elem(0, 0), 8);
        fill(3, 5);
        do_op(EWISE, 0);
        check("ewise_15", elem(1, 2), 15);
        check("ewise_15b", elem(3, 0), 15);

        // Wrap-around and clear
        fill(16'hFFFF, 16'hFFFF);
        do_op(MUL, 0);
        check("max_mul", elem(0, 3), 32'hFFF80004);
        check("max_ovf", bus.ovf, 1);
        do_op(CLR, 0);
        check("clear_result", elem(2, 2), 0);
        check("clear_ovf", bus.ovf, 0);

        // Long hold in DONE with input noise
        fill_random(0);
        do_op(MUL, 10);

        // Asynchronous reset during COMPUTE at k=2
        fill_random(0);
        accept_op(MUL);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        model_zero();
        #1;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        check("midreset_result", elem(1, 1), 0);
        check("midreset_ovf", bus.ovf, 0);
        @(negedge clk);
        reset = 1'b1;
        fill_random(1);
        do_op(MUL, 0);

        // Randomized operation mix
        for (int i = 0; i < 40; i++) begin
            fill_random($urandom_range(0, 2));
            do_op(2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
